// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU signal, ALUOp and funct encodings shared by decode, ID/EX and ALU
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/alu_control.sv
// rtl/alu_control.sv - ALUOp/funct to ALU Signal, invertB and illegal-funct flag
module alu_control
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] signal,
  output logic       invert_b,
  output logic       illegal
);

  // Translate the decoder's ALUOp (and funct for R-type) into ALU slice controls
  always_comb begin
    signal  = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: signal = ALU_ADD;
      ALUOP_SUB: signal = ALU_SUB;
      ALUOP_OR:  signal = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: signal = ALU_ADD;
          FUNCT_SUB: signal = ALU_SUB;
          FUNCT_AND: signal = ALU_AND;
          FUNCT_OR:  signal = ALU_OR;
          FUNCT_SLT: signal = ALU_SLT;
          default:   illegal = 1'b1;
        endcase
      end
    endcase
  end

  // SUB and SLT both need B inverted with carry-in, which is exactly Signal[2]
  assign invert_b = signal[2];

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with stall/flush and bubble counter
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_alu_signal,
  output logic              ex_invert_b,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [2:0] dec_signal;
  logic       dec_invert_b;
  logic       dec_illegal;

  alu_control u_alu_control (
    .alu_op   (id_alu_op),
    .funct    (id_funct),
    .signal   (dec_signal),
    .invert_b (dec_invert_b),
    .illegal  (dec_illegal)
  );

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [2:0]        signal_q, signal_d;
  logic              invert_b_q, invert_b_d;
  logic              alu_src_q, alu_src_d, reg_dst_q, reg_dst_d, mem_to_reg_q, mem_to_reg_d;
  logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_bubble;
  logic              side_ok;

  // Next-state: flush beats stall beats load; side effects only for valid, legal slots
  always_comb begin
    valid_d      = valid_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    signal_d     = signal_q;
    invert_b_d   = invert_b_q;
    alu_src_d    = alu_src_q;
    reg_dst_d    = reg_dst_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    illegal_d    = illegal_q;
    side_ok      = id_valid & ~dec_illegal;
    load_bubble  = flush | (~stall & ~id_valid);
    if (flush) begin
      valid_d      = 1'b0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      signal_d     = ALU_ADD;
      invert_b_d   = 1'b0;
      alu_src_d    = 1'b0;
      reg_dst_d    = 1'b0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      illegal_d    = 1'b0;
    end else if (!stall) begin
      valid_d      = id_valid;
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
      rs_d         = id_rs;
      rt_d         = id_rt;
      rd_d         = id_rd;
      signal_d     = dec_signal;
      invert_b_d   = dec_invert_b;
      alu_src_d    = id_alu_src;
      reg_dst_d    = id_reg_dst;
      mem_to_reg_d = id_mem_to_reg;
      reg_write_d  = id_reg_write & side_ok;
      mem_read_d   = id_mem_read & side_ok;
      mem_write_d  = id_mem_write & side_ok;
      illegal_d    = id_valid & dec_illegal;
    end
    cnt_d = (load_bubble && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Pipeline register; async reset leaves an ADD bubble with a cleared counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      signal_q     <= ALU_ADD;
      invert_b_q   <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      signal_q     <= signal_d;
      invert_b_q   <= invert_b_d;
      alu_src_q    <= alu_src_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      illegal_q    <= illegal_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_rs_data    = rs_data_q;
  assign ex_rt_data    = rt_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_alu_signal = signal_q;
  assign ex_invert_b   = invert_b_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_reg_dst    = reg_dst_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_illegal    = illegal_q;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [REG_AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [1:0] id_alu_op = '0;
  logic [5:0] id_funct = '0;
  logic id_alu_src = 0, id_reg_dst = 0, id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_mem_to_reg = 0;

  logic ex_valid;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [2:0] ex_alu_signal;
  logic ex_invert_b, ex_alu_src, ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_alu_signal(ex_alu_signal),
    .ex_invert_b(ex_invert_b), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state: what EX should show after the most recent edge
  logic m_valid;
  logic [DATA_W-1:0] m_rs_data, m_rt_data, m_imm;
  logic [REG_AW-1:0] m_rs, m_rt, m_rd;
  logic [2:0] m_sig;
  logic m_src, m_dst, m_mtr, m_rw, m_mr, m_mw, m_ill, m_flushed;
  int m_cnt;

  // {illegal, signal} straight from the ALU control table
  function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return {1'b0, 3'b010};
    if (op == 2'b01) return {1'b0, 3'b110};
    if (op == 2'b11) return {1'b0, 3'b001};
    if (f == 6'h20) return {1'b0, 3'b010};
    if (f == 6'h22) return {1'b0, 3'b110};
    if (f == 6'h24) return {1'b0, 3'b000};
    if (f == 6'h25) return {1'b0, 3'b001};
    if (f == 6'h2A) return {1'b0, 3'b111};
    return {1'b1, 3'b010};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_sig = 3'b010;
    m_src = 0; m_dst = 0; m_mtr = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ill = 0;
    m_flushed = 1; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [3:0] dec;
    if (flush) begin
      m_valid = 0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_sig = 3'b010;
      m_rw = 0; m_mr = 0; m_mw = 0; m_ill = 0; m_flushed = 1;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (!stall) begin
      dec = ref_decode(id_alu_op, id_funct);
      m_valid = id_valid; m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_sig = dec[2:0];
      m_src = id_alu_src; m_dst = id_reg_dst; m_mtr = id_mem_to_reg;
      m_ill = id_valid && dec[3];
      m_rw = id_reg_write && id_valid && !dec[3];
      m_mr = id_mem_read && id_valid && !dec[3];
      m_mw = id_mem_write && id_valid && !dec[3];
      m_flushed = 0;
      if (!id_valid && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs();
    logic [5:0] legal [5];
    legal = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    id_valid = ($urandom_range(0, 3) != 0);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs = REG_AW'($urandom); id_rt = REG_AW'($urandom); id_rd = REG_AW'($urandom);
    id_alu_op = 2'($urandom);
    id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 4)];
    id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom); id_reg_write = 1'($urandom);
    id_mem_read = 1'($urandom); id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
  endtask

  task automatic test_reset();
    rand_inputs(); id_valid = 1; id_alu_op = 2'b01; stall = 0; flush = 0;
    tick();
    n_tests++;
    if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_valid got %b exp 1", ex_valid); end
    #3 rst_n = 0;
    #1;
    n_tests++;
    if ({ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_invert_b, ex_alu_src,
         ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal, bubble_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_zero got valid=%b rs_data=%h cnt=%0d exp all zero", ex_valid, ex_rs_data, bubble_cnt);
    end
    n_tests++;
    if (ex_alu_signal !== 3'b010) begin n_fail++; $display("FAIL reset_signal got %b exp 010", ex_alu_signal); end
    model_reset();
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_decode();
    logic [1:0] ops [8];
    logic [5:0] fns [8];
    logic [2:0] sigs [8];
    ops  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h22, 6'h20, 6'h24};
    sigs = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b110, 3'b001};
    for (int i = 0; i < 8; i++) begin
      rand_inputs(); id_valid = 1; stall = 0; flush = 0;
      id_alu_op = ops[i]; id_funct = fns[i];
      tick();
      n_tests++;
      if ({ex_alu_signal, ex_invert_b, ex_illegal} !== {sigs[i], sigs[i][2], 1'b0}) begin
        n_fail++;
        $display("FAIL decode_%0d got sig=%b inv=%b ill=%b exp sig=%b inv=%b ill=0",
                 i, ex_alu_signal, ex_invert_b, ex_illegal, sigs[i], sigs[i][2]);
      end
    end
  endtask

  task automatic test_illegal();
    rand_inputs(); id_valid = 1; stall = 0; flush = 0;
    id_alu_op = 2'b10; id_funct = 6'h3F; id_reg_write = 1; id_mem_write = 1; id_mem_read = 1;
    tick();
    n_tests++;
    if ({ex_valid, ex_illegal, ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_signal} !== {5'b11000, 3'b010}) begin
      n_fail++;
      $display("FAIL illegal got v=%b ill=%b rw=%b mw=%b mr=%b sig=%b exp v=1 ill=1 rw=0 mw=0 mr=0 sig=010",
               ex_valid, ex_illegal, ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_signal);
    end
  endtask

  task automatic test_stall();
    int cnt0;
    rand_inputs(); id_valid = 1; stall = 0; flush = 0; id_rs_data = 32'h1234_5678;
    tick();
    cnt0 = m_cnt;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      rand_inputs(); stall = 1;
      tick();
      n_tests++;
      if (ex_rs_data !== 32'h1234_5678 || ex_valid !== 1'b1 || int'(bubble_cnt) != cnt0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d got rs_data=%h valid=%b cnt=%0d exp 12345678 1 %0d", k, ex_rs_data, ex_valid, bubble_cnt, cnt0);
      end
    end
    rand_inputs(); id_valid = 1; stall = 0; id_rs_data = 32'hCAFE_0001;
    tick();
    n_tests++;
    if (ex_rs_data !== 32'hCAFE_0001) begin n_fail++; $display("FAIL stall_release got %h exp cafe0001", ex_rs_data); end
  endtask

  task automatic test_flush_stall();
    int cnt0;
    cnt0 = m_cnt;
    rand_inputs(); id_valid = 1; id_mem_write = 1; id_alu_op = 2'b10; id_funct = 6'h2A;
    stall = 1; flush = 1;
    tick();
    n_tests++;
    if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || ex_alu_signal !== 3'b010 || ex_invert_b !== 1'b0
        || int'(bubble_cnt) != cnt0 + 1) begin
      n_fail++;
      $display("FAIL flush_stall got v=%b mw=%b sig=%b inv=%b cnt=%0d exp 0 0 010 0 %0d",
               ex_valid, ex_mem_write, ex_alu_signal, ex_invert_b, bubble_cnt, cnt0 + 1);
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_random();
    logic [127:0] got, exp;
    for (int c = 0; c < 300; c++) begin
      rand_inputs();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      tick();
      got = {ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_alu_signal, ex_invert_b,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, bubble_cnt};
      exp = {m_valid, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_rd, m_sig, m_sig[2],
             m_rw, m_mr, m_mw, m_ill, CNT_W'(m_cnt)};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL random_core_%0d got %h exp %h", c, got, exp); end
      if (!m_flushed) begin
        n_tests++;
        if ({ex_alu_src, ex_reg_dst, ex_mem_to_reg} !== {m_src, m_dst, m_mtr}) begin
          n_fail++;
          $display("FAIL random_ctrl_%0d got %b%b%b exp %b%b%b", c, ex_alu_src, ex_reg_dst, ex_mem_to_reg, m_src, m_dst, m_mtr);
        end
      end
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_saturation();
    flush = 1;
    for (int k = 0; k < 20; k++) tick();
    n_tests++;
    if (int'(bubble_cnt) != CNT_MAX) begin n_fail++; $display("FAIL sat_flush got %0d exp %0d", bubble_cnt, CNT_MAX); end
    flush = 0; stall = 1;
    tick();
    n_tests++;
    if (int'(bubble_cnt) != CNT_MAX) begin n_fail++; $display("FAIL sat_stall got %0d exp %0d", bubble_cnt, CNT_MAX); end
    stall = 0; id_valid = 0;
    tick();
    n_tests++;
    if (int'(bubble_cnt) != CNT_MAX) begin n_fail++; $display("FAIL sat_bubble got %0d exp %0d", bubble_cnt, CNT_MAX); end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    test_reset();
    test_decode();
    test_illegal();
    test_stall();
    test_flush_stall();
    test_reset();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the pipelined CPU, directly upstream of the execute-stage ALU (ripple array of 1-bit slices). It captures decoded operands and control from the decode stage, translates ALUOp/funct into the ALU's 3-bit `Signal` and `invertB` controls, and presents everything registered to EX. It applies the hazard unit's stall (hold) and flush (bubble) commands and counts inserted bubbles for observability.

## Interface
- `DATA_W`, 32, operand/immediate width
- `REG_AW`, 5, register address width
- `CNT_W`, 16, bubble counter width

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `stall`  in  1  hold all EX outputs this cycle
- `flush`  in  1  load a bubble this cycle
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rs_data`, `id_rt_data`, `id_imm`  in  DATA_W each  operands, sign-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  REG_AW each  register addresses
- `id_alu_op`  in  2  00 add, 01 sub, 10 R-type, 11 or
- `id_funct`  in  6  R-type function field
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1 each  control
- `ex_valid`  out  1  EX slot holds a real instruction
- `ex_rs_data`, `ex_rt_data`, `ex_imm`  out  DATA_W each
- `ex_rs`, `ex_rt`, `ex_rd`  out  REG_AW each
- `ex_alu_signal`  out  3  ALU Signal: AND 000, OR 001, ADD 010, SUB 110, SLT 111
- `ex_invert_b`  out  1  equals `ex_alu_signal[2]`
- `ex_alu_src`, `ex_reg_dst`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  out  1 each
- `ex_illegal`  out  1  R-type with unsupported funct
- `bubble_cnt`  out  CNT_W  saturating count of bubbles loaded

## Operation
- ALU control decode (combinational, before register): alu_op 00→ADD; 01→SUB; 11→OR; 10→funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct→ADD with illegal=1.
- Illegal instruction: register loads with `ex_illegal`=1 and `ex_reg_write`, `ex_mem_write`, `ex_mem_read` forced 0; `ex_valid` follows `id_valid`.
- Each edge, priority: flush > stall > load.
  - flush: load bubble — `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_illegal` = 0, `ex_alu_signal`=ADD (010), `ex_invert_b`=0; data/address fields are don't-care but are loaded with zero.
  - stall (no flush): all outputs including `bubble_cnt` hold.
  - load: capture all id_* fields and decode results. If `id_valid`=0, side-effect controls (reg_write, mem_read, mem_write, illegal) are forced 0 — a bubble.
- `bubble_cnt` increments by 1 on each edge that loads a bubble (flush, or load with `id_valid`=0); saturates at 2^CNT_W−1; cleared only by reset.

## Timing
- Latency: 1 cycle, ID inputs at edge N visible on EX outputs after edge N.
- Reset (rst_n low, any time, asynchronous): every output 0 except `ex_alu_signal`=010; `bubble_cnt`=0. Reset mid-stall discards the held instruction.
- First edge after rst_n rises performs a normal load/stall/flush evaluation.
- stall held for K cycles: outputs stable for K cycles, then next non-stalled edge loads current ID inputs.
- flush and stall asserted together: bubble loaded, counter increments.
- No combinational path from any input to any output.

## Structure
- Shared package `alu_pkg`: Signal encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), ALUOp encodings, funct constants — also consumed by the ALU and the decoder.
- One sub-module: `alu_control` (alu_op, funct → signal[2:0], invert_b, illegal), purely combinational; the register, priority logic and counter live in `id_ex_stage`.

## Test plan
- Reset: assert rst_n=0 mid-run with ex_valid=1 → all outputs zero, `ex_alu_signal`=010, `bubble_cnt`=0 immediately, without a clock edge.
- Decode sweep: alu_op=10 with funct 0x20/0x22/0x24/0x25/0x2A → signal 010/110/000/001/111, invert_b 0/1/0/0/1; alu_op 00/01/11 → 010/110/001.
- Illegal: alu_op=10, funct=0x3F, id_reg_write=1 → ex_illegal=1, ex_reg_write=0, signal=010.
- Stall: load rs_data=0x1234_5678, stall 3 cycles while ID inputs change → outputs hold 0x1234_5678 three cycles, new value appears after stall drops.
- Flush+stall same edge with id_valid=1, id_mem_write=1 → ex_valid=0, ex_mem_write=0, bubble_cnt +1.
- Counter saturation: CNT_W=4, 20 consecutive flushes → bubble_cnt stops at 15; a stall does not change it.
